bp_io_scratch_responder: RTL and testbench

Device-side endpoint of the uncached I/O memory channel. It accepts BedRock mem commands on the I/O command port, services each one from a small local 64-bit scratch register file after a fixed latency, and returns a BedRock mem response on the I/O response port. It is the responder at the far end of the I/O CCE's `io_cmd` / `io_resp` path, used as a debug and scratch device and as a latency-controllable test target.

---
 rtl/bp_io_scratch_responder.sv | 218 +++++++++++++++++++++
 tb/tb_bp_io_scratch_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_scratch_responder.sv
// I/O-channel scratch responder: services BedRock mem commands from a small 64-bit register file after a fixed latency.
// Optional feature macro: BP_IO_SCRATCH_OOR_ERR_EN (out-of-range address check; default build wraps the index).
package bp_io_scratch_pkg;

    typedef enum logic [7:0] {
        e_bp_default_cfg = 8'd0
    } bp_params_e;

    localparam int unsigned paddr_width_gp     = 40;
    localparam int unsigned cce_block_width_gp = 512;
    localparam int unsigned lce_id_width_gp    = 4;
    localparam int unsigned lce_assoc_gp       = 8;
    localparam int unsigned way_id_width_gp    = $clog2(lce_assoc_gp);

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] lce_id;
        logic [way_id_width_gp-1:0] way_id;
        logic                       uncached;
        logic                       speculative;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_type_e      msg_type;
        logic [3:0]                subop;
        logic [paddr_width_gp-1:0] addr;
        logic [2:0]                size;
        bp_bedrock_mem_payload_s   payload;
    } bp_bedrock_mem_header_s;

    typedef struct packed {
        bp_bedrock_mem_header_s        header;
        logic [cce_block_width_gp-1:0] data;
    } bp_bedrock_mem_msg_s;

    localparam int unsigned cce_mem_msg_width_gp = $bits(bp_bedrock_mem_msg_s);

endpackage

module bp_io_scratch_responder
    import bp_io_scratch_pkg::*;
#(
    parameter bp_params_e  bp_params_p = e_bp_default_cfg,
    parameter int unsigned els_p       = 16,
    parameter int unsigned latency_p   = 2,
    localparam int unsigned cce_mem_msg_width_lp = cce_mem_msg_width_gp
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_then_o,
    output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_yumi_i,
    output logic                            err_o
);

    localparam int unsigned idx_width_lp  = $clog2(els_p);
    localparam int unsigned cnt_width_lp  = 4;
    localparam int unsigned word_width_lp = 64;

    if (bp_params_p != e_bp_default_cfg) begin : g_cfg_chk
        $error("bp_io_scratch_responder: only e_bp_default_cfg is provided");
    end
    if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_els_chk
        $error("bp_io_scratch_responder: els_p must be a power of two >= 2");
    end
    if (latency_p < 1 || latency_p > 15) begin : g_lat_chk
        $error("bp_io_scratch_responder: latency_p must be in 1..15");
    end

    typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

    state_e                     r_state, w_state_n;
    logic [cnt_width_lp-1:0]    r_cnt, w_cnt_n;
    logic                       r_ready, r_resp_v, r_err;
    bp_bedrock_mem_header_s     r_hdr;
    logic [word_width_lp-1:0]   r_rdata;
    logic [word_width_lp-1:0]   r_mem [els_p];

    bp_bedrock_mem_msg_s        w_cmd, w_resp;
    logic                       w_accept;
    logic [idx_width_lp-1:0]    w_idx;
    logic [2:0]                 w_off;
    logic [5:0]                 w_shift;
    logic [word_width_lp-1:0]   w_size_mask, w_word, w_wr_mask, w_wr_data, w_new_word, w_rd_data;
    logic                       w_size_ok, w_is_wr, w_is_rd, w_oor, w_do_wr, w_cmd_err;
    logic                       w_unused;

    assign w_cmd    = bp_bedrock_mem_msg_s'(io_cmd_i);
    assign w_accept = io_cmd_v_i & r_ready;
    assign w_unused = ^{w_cmd.data[cce_block_width_gp-1:word_width_lp], w_cmd.header.addr};

    // Command decode: byte lane selection, write merge and read extraction on the addressed word
    always_comb begin
        w_idx = w_cmd.header.addr[3 +: idx_width_lp];
        case (w_cmd.header.size[1:0])
            2'd0: begin
                w_size_mask = 64'h0000_0000_0000_00ff;
                w_off       = w_cmd.header.addr[2:0];
            end
            2'd1: begin
                w_size_mask = 64'h0000_0000_0000_ffff;
                w_off       = {w_cmd.header.addr[2:1], 1'b0};
            end
            2'd2: begin
                w_size_mask = 64'h0000_0000_ffff_ffff;
                w_off       = {w_cmd.header.addr[2], 2'b00};
            end
            default: begin
                w_size_mask = 64'hffff_ffff_ffff_ffff;
                w_off       = 3'b000;
            end
        endcase
        w_shift   = {w_off, 3'b000};
        w_size_ok = ~w_cmd.header.size[2];
        w_is_wr   = (w_cmd.header.msg_type == e_bedrock_mem_wr)
                  | (w_cmd.header.msg_type == e_bedrock_mem_uc_wr);
        w_is_rd   = (w_cmd.header.msg_type == e_bedrock_mem_rd)
                  | (w_cmd.header.msg_type == e_bedrock_mem_uc_rd);
`ifdef BP_IO_SCRATCH_OOR_ERR_EN
        w_oor     = (w_cmd.header.addr >> (3 + idx_width_lp)) != '0;
`else
        w_oor     = 1'b0;
`endif
        w_word     = r_mem[w_idx];
        w_wr_mask  = w_size_mask << w_shift;
        w_wr_data  = w_cmd.data[word_width_lp-1:0] << w_shift;
        w_new_word = (w_word & ~w_wr_mask) | (w_wr_data & w_wr_mask);
        w_do_wr    = w_accept & w_is_wr & w_size_ok & ~w_oor;
        w_cmd_err  = ~(w_is_wr | w_is_rd) | ~w_size_ok | w_oor;
        w_rd_data  = '0;
        if (w_is_rd && w_size_ok) begin
            w_rd_data = w_oor ? w_size_mask : ((w_word >> w_shift) & w_size_mask);
        end
    end

    // Next-state: accept, count out the latency, then hold the response until yumi
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        unique case (r_state)
            e_ready: begin
                if (w_accept) begin
                    w_cnt_n   = cnt_width_lp'(1);
                    w_state_n = (latency_p == 1) ? e_resp : e_wait;
                end
            end
            e_wait: begin
                w_cnt_n = r_cnt + cnt_width_lp'(1);
                if (w_cnt_n == cnt_width_lp'(latency_p)) begin
                    w_state_n = e_resp;
                end
            end
            e_resp: begin
                if (io_resp_yumi_i) begin
                    w_state_n = e_ready;
                end
            end
            default: w_state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= e_ready;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_resp_v <= 1'b0;
            r_err    <= 1'b0;
            r_hdr    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_ready  <= (w_state_n == e_ready);
            r_resp_v <= (w_state_n == e_resp);
            if (w_accept) begin
                r_hdr   <= w_cmd.header;
                r_rdata <= w_rd_data;
                if (w_cmd_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(els_p); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_wr) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

    always_comb begin
        w_resp        = '0;
        w_resp.header = r_hdr;
        w_resp.data   = cce_block_width_gp'(r_rdata);
    end

    assign io_resp_o           = w_resp;
    assign io_resp_v_o         = r_resp_v;
    assign io_cmd_ready_then_o = r_ready;
    assign err_o               = r_err;

endmodule

// File: tb/tb_bp_io_scratch_responder.sv
// Self-checking bench for bp_io_scratch_responder: directed scenarios plus randomized commands against a byte-level model.
module tb_bp_io_scratch_responder;
    import bp_io_scratch_pkg::*;

    localparam int unsigned ELS = 16;
    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 640;
`ifdef BP_IO_SCRATCH_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic                            clk = 1'b0;
    logic                            rst_n;
    bp_bedrock_mem_msg_s             cmd_i;
    logic                            cmd_v;
    logic                            ready;
    logic [cce_mem_msg_width_gp-1:0] resp;
    logic                            resp_v;
    logic                            yumi;
    logic                            err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [63:0] mdl_mem [ELS];
    bit          mdl_err;

    bp_io_scratch_responder #(
        .bp_params_p (e_bp_default_cfg),
        .els_p       (ELS),
        .latency_p   (LAT)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (rst_n),
        .io_cmd_i            (cmd_i),
        .io_cmd_v_i          (cmd_v),
        .io_cmd_ready_then_o (ready),
        .io_resp_o           (resp),
        .io_resp_v_o         (resp_v),
        .io_resp_yumi_i      (yumi),
        .err_o               (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < int'(ELS); i++) mdl_mem[i] = '0;
        mdl_err = 1'b0;
    endfunction

    // Reference behaviour: byte-by-byte access to the addressed word, serialised in command order
    function automatic bp_bedrock_mem_msg_s model_exec(input bp_bedrock_mem_msg_s c);
        bp_bedrock_mem_msg_s r;
        int  nbytes, off, idx;
        bit  is_wr, is_rd, legal, oor;
        r        = '0;
        r.header = c.header;
        is_wr = (c.header.msg_type == e_bedrock_mem_wr) || (c.header.msg_type == e_bedrock_mem_uc_wr);
        is_rd = (c.header.msg_type == e_bedrock_mem_rd) || (c.header.msg_type == e_bedrock_mem_uc_rd);
        legal = (c.header.size < 3'd4);
        oor   = OOR_EN && (c.header.addr >= 40'(8 * ELS));
        nbytes = legal ? (1 << c.header.size) : 1;
        idx    = int'((c.header.addr / 8) % ELS);
        off    = (int'(c.header.addr % 8) / nbytes) * nbytes;
        if (!(is_wr || is_rd) || !legal || oor) mdl_err = 1'b1;
        if (legal && is_wr && !oor)
            for (int b = 0; b < nbytes; b++) mdl_mem[idx][8*(off+b) +: 8] = c.data[8*b +: 8];
        if (legal && is_rd)
            for (int b = 0; b < nbytes; b++) r.data[8*b +: 8] = oor ? 8'hFF : mdl_mem[idx][8*(off+b) +: 8];
        return r;
    endfunction

    function automatic bp_bedrock_mem_msg_s mk(input bp_bedrock_mem_type_e t, input logic [39:0] a,
                                               input logic [2:0] sz, input logic [63:0] d);
        bp_bedrock_mem_msg_s m;
        m = '0;
        m.header.msg_type            = t;
        m.header.subop               = 4'($urandom);
        m.header.addr                = a;
        m.header.size                = sz;
        m.header.payload.lce_id      = 4'($urandom);
        m.header.payload.way_id      = 3'($urandom);
        m.header.payload.uncached    = 1'($urandom);
        m.header.payload.speculative = 1'($urandom);
        for (int w = 0; w < 16; w++) m.data[32*w +: 32] = $urandom;
        m.data[63:0] = d;
        return m;
    endfunction

    // Issue one command (entered and left on a negedge), check latency, hold-off stability and handshake
    task automatic run_cmd(input bp_bedrock_mem_msg_s c, input int ydly, output int acc);
        bp_bedrock_mem_msg_s exp;
        int n;
        acc = -1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            check_eq("ready_timeout", CW'(ready), CW'(1));
            return;
        end
        exp   = model_exec(c);
        cmd_i = c;
        cmd_v = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        cmd_v = 1'b0;
        cmd_i = mk(bp_bedrock_mem_type_e'(4'($urandom)), 40'($urandom), 3'($urandom), {$urandom, $urandom});
        @(negedge clk);
        n = 0;
        while (resp_v !== 1'b1 && n < 40) begin
            check_eq("ready_busy", CW'(ready), CW'(0));
            @(negedge clk);
            n++;
        end
        check_eq("latency", CW'(n), CW'(LAT - 1));
        if (resp_v !== 1'b1) return;
        for (int k = 0; k < ydly; k++) begin
            check_eq("resp_hold", CW'(resp), CW'(exp));
            check_eq("ready_hold", CW'(ready), CW'(0));
            @(negedge clk);
        end
        check_eq("resp", CW'(resp), CW'(exp));
        check_eq("err", CW'(err), CW'(mdl_err));
        yumi = 1'b1;
        @(posedge clk);
        #1;
        yumi = 1'b0;
        @(negedge clk);
        check_eq("ready_after_yumi", CW'(ready), CW'(1));
        check_eq("v_after_yumi", CW'(resp_v), CW'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_v = 1'b0;
        yumi  = 1'b0;
        #1;
        check_eq("rst_ready", CW'(ready), CW'(0));
        check_eq("rst_v", CW'(resp_v), CW'(0));
        check_eq("rst_err", CW'(err), CW'(0));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("ready_pre_clk", CW'(ready), CW'(0));
        @(negedge clk);
        check_eq("ready_post_clk", CW'(ready), CW'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, prev, r;
        logic [39:0]          addr;
        logic [2:0]           sz;
        bp_bedrock_mem_type_e t;

        rst_n = 1'b0;
        cmd_v = 1'b0;
        yumi  = 1'b0;
        cmd_i = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("init_ready", CW'(ready), CW'(0));
        check_eq("init_v", CW'(resp_v), CW'(0));
        check_eq("init_err", CW'(err), CW'(0));
        rst_n = 1'b1;
        #1;
        check_eq("init_ready_pre", CW'(ready), CW'(0));
        @(negedge clk);
        check_eq("init_ready_post", CW'(ready), CW'(1));

        // Full-word write then read-back
        run_cmd(mk(e_bedrock_mem_uc_wr, 40'h10, 3'd3, 64'h1122334455667788), 0, a);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h10, 3'd3, 64'h0), 0, a);

        // Byte write into a fresh word, then sub-word and full-word reads
        do_reset();
        run_cmd(mk(e_bedrock_mem_uc_wr, 40'h13, 3'd0, 64'h00000000000000AB), 0, a);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h10, 3'd2, 64'h0), 0, a);
        run_cmd(mk(e_bedrock_mem_rd, 40'h13, 3'd3, 64'h0), 0, a);

        // Response held under withheld yumi
        run_cmd(mk(e_bedrock_mem_wr, 40'h2E, 3'd1, 64'hC0DE), 4, a);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h2F, 3'd1, 64'h0), 4, a);

        // Back-to-back with immediate yumi: one command per LAT+1 cycles
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_cmd(mk((i % 2) ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr, 40'(8 * i), 3'd3,
                       {$urandom, $urandom}), 0, a);
            if (i > 0) check_eq("b2b_gap", CW'(a - prev), CW'(LAT + 1));
            prev = a;
        end

        // Reset during the latency window discards the command and clears the scratch
        run_cmd(mk(e_bedrock_mem_uc_wr, 40'h10, 3'd3, 64'hDEADBEEFCAFEF00D), 0, a);
        while (ready !== 1'b1) @(negedge clk);
        cmd_i = mk(e_bedrock_mem_uc_wr, 40'h10, 3'd3, 64'h5555555555555555);
        cmd_v = 1'b1;
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_v", CW'(resp_v), CW'(0));
        check_eq("midrst_ready", CW'(ready), CW'(0));
        model_clear();
        @(negedge clk);
        check_eq("midrst_v_hold", CW'(resp_v), CW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h10, 3'd3, 64'h0), 0, a);

        // Illegal size: no write, zero data, sticky error
        do_reset();
        run_cmd(mk(e_bedrock_mem_uc_wr, 40'h20, 3'd5, 64'hFFFFFFFFFFFFFFFF), 0, a);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h20, 3'd3, 64'h0), 0, a);

        // Unsupported message type
        do_reset();
        run_cmd(mk(e_bedrock_mem_amo, 40'h08, 3'd3, 64'h1234), 0, a);
        run_cmd(mk(e_bedrock_mem_rd, 40'h08, 3'd3, 64'h0), 1, a);

        // Address beyond the scratch: aliases word 0, or out-of-range when checked
        do_reset();
        run_cmd(mk(e_bedrock_mem_uc_wr, 40'h00, 3'd3, 64'h0123456789ABCDEF), 0, a);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h80, 3'd3, 64'h0), 0, a);
        run_cmd(mk(e_bedrock_mem_uc_rd, 40'h84, 3'd1, 64'h0), 0, a);

        // Randomized traffic, periodically reset so the error flag stays informative
        for (int i = 0; i < 240; i++) begin
            if (i % 40 == 0) do_reset();
            r = $urandom_range(0, 19);
            t = (r < 19) ? bp_bedrock_mem_type_e'(4'(r % 4)) : bp_bedrock_mem_type_e'(4'($urandom_range(4, 15)));
            sz = ($urandom_range(0, 19) < 19) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            r = $urandom_range(0, 19);
            if (r < 17)       addr = 40'($urandom_range(0, 8 * ELS - 1));
            else if (r < 19)  addr = 40'($urandom_range(8 * ELS, 16 * ELS - 1));
            else              addr = {8'($urandom), $urandom};
            run_cmd(mk(t, addr, sz, {$urandom, $urandom}), $urandom_range(0, 3), a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
